// File: rtl/pe_mw.sv
// pe_mw: weight-stationary systolic PE holding a bank of WGT_DEPTH weights
// that are loaded over a daisy-chained ID bus and fed to a 3-stage MAC pipeline.
//
// Ports:
//   clk, rst        clock; asynchronous active-low reset
//   i_signed        1 = signed arithmetic (change only while the pipeline is idle)
//   i_clr           synchronous clear of load/pop indices, weight count and full flag
//   i_load_*        load bus in: valid, target ID, weight value
//   o_load_*        load bus out: registered copy; words consumed here are not forwarded
//   o_wgt_full      all WGT_DEPTH weights loaded since the last reset or clear
//   i_pop_vld       MAC valid; advances the pop index
//   o_pop_vld       i_pop_vld delayed 3 cycles, aligned with o_down_data
//   i_up_data       partial sum from the PE above
//   i_left_data     activation from the PE to the left
//   o_right_data    activation to the right, 1-cycle skew
//   o_down_data     partial sum to the PE below, 3-cycle latency
module pe_mw #(
  parameter int ID_VAL         = 0,
  parameter int ID_WIDTH       = 6,
  parameter int IN_DATA_WIDTH  = 8,
  parameter int OUT_DATA_WIDTH = 24,
  parameter int WGT_DEPTH      = 4,
  parameter int SAT_EN         = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_signed,
  input  logic                      i_clr,
  input  logic                      i_load_vld,
  input  logic [ID_WIDTH-1:0]       i_load_id,
  input  logic [IN_DATA_WIDTH-1:0]  i_load_data,
  output logic                      o_load_vld,
  output logic [ID_WIDTH-1:0]       o_load_id,
  output logic [IN_DATA_WIDTH-1:0]  o_load_data,
  output logic                      o_wgt_full,
  input  logic                      i_pop_vld,
  output logic                      o_pop_vld,
  input  logic [OUT_DATA_WIDTH-1:0] i_up_data,
  input  logic [IN_DATA_WIDTH-1:0]  i_left_data,
  output logic [IN_DATA_WIDTH-1:0]  o_right_data,
  output logic [OUT_DATA_WIDTH-1:0] o_down_data
);

  localparam int IW = IN_DATA_WIDTH;
  localparam int OW = OUT_DATA_WIDTH;
  localparam int PW = 2 * IW;
  localparam int SW = OW + 1;
  localparam int AW = (WGT_DEPTH > 1) ? $clog2(WGT_DEPTH) : 1;
  localparam int CW = $clog2(WGT_DEPTH + 1);

  localparam logic [ID_WIDTH-1:0] MY_ID = ID_WIDTH'(ID_VAL);
  localparam logic [CW-1:0] LAST_CNT = CW'(WGT_DEPTH - 1);

  // ---------------------------------------------------------------
  // Load side
  // ---------------------------------------------------------------
  logic [IW-1:0] wgt_q [WGT_DEPTH];

  logic [AW-1:0] load_idx_q, load_idx_d;
  logic [AW-1:0] pop_idx_q, pop_idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          full_q, full_d;

  logic                lvld_q, lvld_d;
  logic [ID_WIDTH-1:0] lid_q;
  logic [IW-1:0]       ldata_q;

  logic take;
  logic hit;

  // take: the word is addressed to us and we still have room.
  // A clear cancels the write but the word is still consumed.
  assign take = i_load_vld & (i_load_id == MY_ID) & ~full_q;
  assign hit  = take & ~i_clr;

  always_comb begin
    load_idx_d = load_idx_q;
    pop_idx_d  = pop_idx_q;
    cnt_d      = cnt_q;
    full_d     = full_q;
    lvld_d     = i_load_vld & ~take;
    if (i_clr) begin
      load_idx_d = '0;
      pop_idx_d  = '0;
      cnt_d      = '0;
      full_d     = 1'b0;
    end else begin
      if (hit) begin
        // power-of-2 depth: natural overflow wraps the index
        load_idx_d = load_idx_q + AW'(1);
        cnt_d      = cnt_q + CW'(1);
        if (cnt_q == LAST_CNT) begin
          full_d = 1'b1;
        end
      end
      if (i_pop_vld) begin
        pop_idx_d = pop_idx_q + AW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      load_idx_q <= '0;
      pop_idx_q  <= '0;
      cnt_q      <= '0;
      full_q     <= 1'b0;
      lvld_q     <= 1'b0;
      lid_q      <= '0;
      ldata_q    <= '0;
    end else begin
      load_idx_q <= load_idx_d;
      pop_idx_q  <= pop_idx_d;
      cnt_q      <= cnt_d;
      full_q     <= full_d;
      lvld_q     <= lvld_d;
      lid_q      <= i_load_id;
      ldata_q    <= i_load_data;
    end
  end

  // Weight bank is intentionally not reset.
  always_ff @(posedge clk) begin
    if (hit) begin
      wgt_q[load_idx_q] <= i_load_data;
    end
  end

  assign o_load_vld  = lvld_q;
  assign o_load_id   = lid_q;
  assign o_load_data = ldata_q;
  assign o_wgt_full  = full_q;

  // ---------------------------------------------------------------
  // MAC pipeline
  // ---------------------------------------------------------------
  logic [OW-1:0] s1_up_q;
  logic [IW-1:0] s1_left_q;
  logic [IW-1:0] s1_wgt_q;
  logic          s1_vld_q;

  logic [SW-1:0] s2_sum_q, s2_sum_d;
  logic          s2_vld_q;

  logic [OW-1:0] s3_out_q, s3_out_d;
  logic          s3_vld_q;

  logic [IW-1:0] right_q;

  logic signed [PW-1:0] prod_s;
  logic        [PW-1:0] prod_u;
  logic        [SW-1:0] prod_x;
  logic        [SW-1:0] up_x;

  assign prod_s = $signed(s1_left_q) * $signed(s1_wgt_q);
  assign prod_u = s1_left_q * s1_wgt_q;

  always_comb begin
    prod_x = {{(SW-PW){1'b0}}, prod_u};
    up_x   = {1'b0, s1_up_q};
    if (i_signed) begin
      prod_x = {{(SW-PW){prod_s[PW-1]}}, prod_s};
      up_x   = {s1_up_q[OW-1], s1_up_q};
    end
    s2_sum_d = prod_x + up_x;
  end

  localparam logic [OW-1:0] S_MAX = {1'b0, {(OW-1){1'b1}}};
  localparam logic [OW-1:0] S_MIN = {1'b1, {(OW-1){1'b0}}};
  localparam logic [OW-1:0] U_MAX = {OW{1'b1}};

  always_comb begin
    s3_out_d = s2_sum_q[OW-1:0];
    if (SAT_EN != 0) begin
      if (i_signed) begin
        // top two bits disagree => result left the OW-bit signed range
        if (s2_sum_q[SW-1] != s2_sum_q[SW-2]) begin
          s3_out_d = s2_sum_q[SW-1] ? S_MIN : S_MAX;
        end
      end else if (s2_sum_q[SW-1]) begin
        s3_out_d = U_MAX;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_up_q   <= '0;
      s1_left_q <= '0;
      s1_wgt_q  <= '0;
      s1_vld_q  <= 1'b0;
      s2_sum_q  <= '0;
      s2_vld_q  <= 1'b0;
      s3_out_q  <= '0;
      s3_vld_q  <= 1'b0;
      right_q   <= '0;
    end else begin
      s1_up_q   <= i_up_data;
      s1_left_q <= i_left_data;
      s1_wgt_q  <= wgt_q[pop_idx_q];
      s1_vld_q  <= i_pop_vld;
      s2_sum_q  <= s2_sum_d;
      s2_vld_q  <= s1_vld_q;
      s3_out_q  <= s3_out_d;
      s3_vld_q  <= s2_vld_q;
      right_q   <= i_left_data;
    end
  end

  assign o_pop_vld    = s3_vld_q;
  assign o_down_data  = s3_out_q;
  assign o_right_data = right_q;

endmodule

// File: tb/tb_pe_mw.sv
// tb_pe_mw: randomized + directed bench for pe_mw against a behavioural model.
// Two instances (saturating and wrapping) share the same stimulus.
module tb_pe_mw;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        sgn;
  logic        clr;
  logic        lvld;
  logic [5:0]  lid;
  logic [7:0]  ldata;
  logic        pop;
  logic [23:0] up;
  logic [7:0]  left;

  logic        s_lvld, w_lvld;
  logic [5:0]  s_lid, w_lid;
  logic [7:0]  s_ldata, w_ldata;
  logic        s_full, w_full;
  logic        s_pvld, w_pvld;
  logic [7:0]  s_right, w_right;
  logic [23:0] s_down, w_down;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pe_mw #(.SAT_EN(1)) u_sat (
    .clk(clk), .rst(rst), .i_signed(sgn), .i_clr(clr),
    .i_load_vld(lvld), .i_load_id(lid), .i_load_data(ldata),
    .o_load_vld(s_lvld), .o_load_id(s_lid), .o_load_data(s_ldata),
    .o_wgt_full(s_full), .i_pop_vld(pop), .o_pop_vld(s_pvld),
    .i_up_data(up), .i_left_data(left),
    .o_right_data(s_right), .o_down_data(s_down)
  );

  pe_mw #(.SAT_EN(0)) u_wrap (
    .clk(clk), .rst(rst), .i_signed(sgn), .i_clr(clr),
    .i_load_vld(lvld), .i_load_id(lid), .i_load_data(ldata),
    .o_load_vld(w_lvld), .o_load_id(w_lid), .o_load_data(w_ldata),
    .o_wgt_full(w_full), .i_pop_vld(pop), .o_pop_vld(w_pvld),
    .i_up_data(up), .i_left_data(left),
    .o_right_data(w_right), .o_down_data(w_down)
  );

  typedef struct {
    logic [23:0] sat;
    logic [23:0] wrap;
    logic        vld;
    bit          chk;
  } ent_t;

  ent_t q[$];

  bit [7:0] m_wgt [DEPTH];
  bit       m_known [DEPTH];
  int       m_li, m_pi, m_cnt;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic ent_t mk(input logic [23:0] u, input logic [7:0] l,
                              input logic [7:0] w, input bit s,
                              input logic v, input bit known);
    ent_t e;
    longint r, c;
    int sl, sw, su;
    if (s) begin
      sl = l[7] ? int'(l) - 256 : int'(l);
      sw = w[7] ? int'(w) - 256 : int'(w);
      su = u[23] ? int'(u) - 16777216 : int'(u);
      r  = longint'(sl * sw) + longint'(su);
      c  = r;
      if (c > 64'sd8388607) c = 64'sd8388607;
      if (c < -64'sd8388608) c = -64'sd8388608;
    end else begin
      r = longint'(l) * longint'(w) + longint'(u);
      c = r;
      if (c > 64'sd16777215) c = 64'sd16777215;
    end
    e.sat  = c[23:0];
    e.wrap = r[23:0];
    e.vld  = v;
    e.chk  = known;
    return e;
  endfunction

  task automatic model_reset();
    ent_t z;
    m_li  = 0;
    m_pi  = 0;
    m_cnt = 0;
    z = mk(24'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1);
    q.delete();
    q.push_back(z);
    q.push_back(z);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_down_s"}, 32'(s_down), 32'd0);
    chk({tag, "_down_w"}, 32'(w_down), 32'd0);
    chk({tag, "_pvld"}, 32'(s_pvld | w_pvld), 32'd0);
    chk({tag, "_right"}, 32'(s_right | w_right), 32'd0);
    chk({tag, "_lvld"}, 32'(s_lvld | w_lvld), 32'd0);
    chk({tag, "_full"}, 32'(s_full | w_full), 32'd0);
  endtask

  task automatic set_sgn(input logic b);
    sgn = b;
    foreach (q[i]) q[i].chk = 1'b0;
  endtask

  // One clock: model the pre-edge inputs, take the edge, compare.
  task automatic step();
    ent_t e, o;
    bit   take;
    logic e_lv;
    logic [5:0] e_id;
    logic [7:0] e_ld, e_r;
    take = lvld && (lid == 6'd0) && (m_cnt != DEPTH);
    e = mk(up, left, m_wgt[m_pi], sgn, pop, m_known[m_pi]);
    q.push_back(e);
    e_lv = lvld && !take;
    e_id = lid;
    e_ld = ldata;
    e_r  = left;
    if (clr) begin
      m_li = 0;
      m_pi = 0;
      m_cnt = 0;
    end else begin
      if (take) begin
        m_wgt[m_li]   = ldata;
        m_known[m_li] = 1'b1;
        m_li  = (m_li + 1) % DEPTH;
        m_cnt = m_cnt + 1;
      end
      if (pop) m_pi = (m_pi + 1) % DEPTH;
    end
    @(posedge clk);
    #1;
    o = q.pop_front();
    chk("pop_vld_s", 32'(s_pvld), 32'(o.vld));
    chk("pop_vld_w", 32'(w_pvld), 32'(o.vld));
    if (o.chk) begin
      chk("down_sat", 32'(s_down), 32'(o.sat));
      chk("down_wrap", 32'(w_down), 32'(o.wrap));
    end
    chk("load_vld", 32'(s_lvld), 32'(e_lv));
    chk("load_id", 32'(s_lid), 32'(e_id));
    chk("load_data", 32'(s_ldata), 32'(e_ld));
    chk("wgt_full", 32'(s_full), 32'(m_cnt == DEPTH));
    chk("right", 32'(s_right), 32'(e_r));
    chk("w_mirror", 32'({w_lvld, w_full, w_lid, w_ldata, w_right}),
        32'({s_lvld, s_full, s_lid, s_ldata, s_right}));
  endtask

  task automatic load(input logic [7:0] d);
    lvld  = 1'b1;
    lid   = 6'd0;
    ldata = d;
    step();
    lvld  = 1'b0;
  endtask

  task automatic mid_reset();
    #2;
    rst = 1'b0;
    #1;
    chk_zero("rst_async");
    model_reset();
    repeat (2) begin
      pop  = ~pop;
      left = 8'($urandom);
      @(posedge clk);
      #1;
      chk_zero("rst_hold");
    end
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; sgn = 1'b0; clr = 1'b0; lvld = 1'b0; lid = '0;
    ldata = '0; pop = 1'b0; up = '0; left = '0;
    foreach (m_known[i]) m_known[i] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b1;
    model_reset();

    // 1: fill, then a 5th word and a foreign word pass through
    for (int i = 1; i <= 4; i++) load(8'(i));
    load(8'd9);
    lvld = 1'b1; lid = 6'd5; ldata = 8'h5a;
    step();
    lvld = 1'b0;

    // 2: unsigned MACs over all four weights and one wrap
    up = 24'd10; left = 8'd5; pop = 1'b1;
    repeat (5) step();
    pop = 1'b0;
    repeat (3) step();

    // 3: reload with signed-interesting weights
    clr = 1'b1; step(); clr = 1'b0;
    load(8'hff); load(8'd127); load(8'h80); load(8'd5);
    set_sgn(1'b1);
    repeat (3) step();
    up = 24'hfffffb; left = 8'h80; pop = 1'b1;
    step();
    pop = 1'b0;
    repeat (3) step();
    set_sgn(1'b0);
    clr = 1'b1; step(); clr = 1'b0;
    repeat (3) step();
    pop = 1'b1; step(); pop = 1'b0;
    repeat (3) step();

    // 4: signed saturation both ways
    set_sgn(1'b1);
    clr = 1'b1; step(); clr = 1'b0;
    repeat (2) step();
    up = 24'd0; left = 8'd0; pop = 1'b1; step();
    up = 24'h7ffff0; left = 8'd127; step();
    up = 24'h800000; left = 8'd127; step();
    pop = 1'b0;
    repeat (3) step();

    // 5: clear racing a hit and a pop
    clr = 1'b1; step(); clr = 1'b0;
    load(8'h11); load(8'h22);
    clr = 1'b1; lvld = 1'b1; lid = 6'd0; ldata = 8'h33; pop = 1'b1;
    step();
    clr = 1'b0; lvld = 1'b0; pop = 1'b1; up = 24'd1; left = 8'd3;
    step();
    pop = 1'b0;
    load(8'h44); load(8'h55); load(8'h66); load(8'h77);
    pop = 1'b1;
    repeat (4) step();
    pop = 1'b0;
    repeat (3) step();

    // randomized traffic with a mid-stream reset
    for (int n = 0; n < 400; n++) begin
      lvld  = 1'($urandom);
      case ($urandom_range(0, 3))
        0, 1:    lid = 6'd0;
        2:       lid = 6'd1;
        default: lid = 6'($urandom);
      endcase
      ldata = 8'($urandom);
      clr   = ($urandom_range(0, 19) == 0);
      pop   = 1'($urandom);
      up    = 24'($urandom);
      left  = 8'($urandom);
      if ($urandom_range(0, 49) == 0) set_sgn(~sgn);
      if (n == 200) mid_reset();
      step();
    end
    clr = 1'b0; lvld = 1'b0; pop = 1'b0;
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
